onchip_mem_arbiter: RTL and testbench

- Two-master Avalon-MM arbiter placed directly upstream of a single-port on-chip RAM slave. Targets 8192x32, byte-enabled, read latency 1.
- Lets two cores in the multi-core platform share one RAM bank, e.g. a shared mailbox or scratch memory.
- Arbitration is fair round-robin.
- Returns read data to the correct master through a readdatavalid pipeline.
- Keeps per-master saturating stall counters for contention profiling.

---
 rtl/onchip_mem_arbiter.sv | 109 ++++++++++
 tb/tb_onchip_mem_arbiter.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/onchip_mem_arbiter.sv
// Two-master Avalon-MM round-robin arbiter in front of a single-port,
// byte-enabled, read-latency-1 on-chip RAM, with per-master stall counters.
module onchip_mem_arbiter #(
  parameter int ADDR_W  = 13,
  parameter int DATA_W  = 32,
  parameter int BE_W    = DATA_W / 8,
  parameter int STALL_W = 16
) (
  input  logic               clk,
  input  logic               reset_n,

  input  logic [ADDR_W-1:0]  m0_address,
  input  logic [BE_W-1:0]    m0_byteenable,
  input  logic               m0_read,
  input  logic               m0_write,
  input  logic [DATA_W-1:0]  m0_writedata,
  output logic               m0_waitrequest,
  output logic [DATA_W-1:0]  m0_readdata,
  output logic               m0_readdatavalid,

  input  logic [ADDR_W-1:0]  m1_address,
  input  logic [BE_W-1:0]    m1_byteenable,
  input  logic               m1_read,
  input  logic               m1_write,
  input  logic [DATA_W-1:0]  m1_writedata,
  output logic               m1_waitrequest,
  output logic [DATA_W-1:0]  m1_readdata,
  output logic               m1_readdatavalid,

  output logic [ADDR_W-1:0]  mem_address,
  output logic [BE_W-1:0]    mem_byteenable,
  output logic               mem_chipselect,
  output logic               mem_write,
  output logic [DATA_W-1:0]  mem_writedata,
  output logic               mem_clken,
  input  logic [DATA_W-1:0]  mem_readdata,

  input  logic               stall_clr,
  output logic [STALL_W-1:0] m0_stall_cnt,
  output logic [STALL_W-1:0] m1_stall_cnt
);

  localparam logic [STALL_W-1:0] STALL_ONE = STALL_W'(1);

  logic req0, req1;
  logic gnt0, gnt1;
  logic rd_accept;
  logic last_grant;
  logic rd_pend;
  logic rd_owner;

  // Handshake: a master holds read/write (with address/data) until it sees
  // waitrequest low; the transfer completes in exactly that cycle.
  assign req0 = m0_read | m0_write;
  assign req1 = m1_read | m1_write;

  // On contention the master that was not served last wins; reset blocks all grants.
  assign gnt0 = reset_n & req0 & (~req1 | last_grant);
  assign gnt1 = reset_n & req1 & (~req0 | ~last_grant);

  // read+write together is a write and never produces return data
  assign rd_accept = (gnt0 & m0_read & ~m0_write) | (gnt1 & m1_read & ~m1_write);

  assign m0_waitrequest = ~gnt0;
  assign m1_waitrequest = ~gnt1;

  assign mem_address    = gnt1 ? m1_address    : m0_address;
  assign mem_byteenable = gnt1 ? m1_byteenable : m0_byteenable;
  assign mem_writedata  = gnt1 ? m1_writedata  : m0_writedata;
  assign mem_chipselect = gnt0 | gnt1;
  assign mem_write      = (gnt0 & m0_write) | (gnt1 & m1_write);
  assign mem_clken      = 1'b1;

  // Gating with reset_n drops a read that was in flight when reset arrived.
  assign m0_readdatavalid = reset_n & rd_pend & ~rd_owner;
  assign m1_readdatavalid = reset_n & rd_pend &  rd_owner;
  assign m0_readdata      = m0_readdatavalid ? mem_readdata : '0;
  assign m1_readdata      = m1_readdatavalid ? mem_readdata : '0;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      last_grant <= 1'b1;
      rd_pend    <= 1'b0;
      rd_owner   <= 1'b0;
    end else begin
      if (gnt0 | gnt1) begin
        last_grant <= gnt1;
      end
      rd_pend  <= rd_accept;
      rd_owner <= gnt1;
    end
  end

  // Saturating stall counters; a clear wins over a same-cycle increment.
  always_ff @(posedge clk) begin
    if (!reset_n || stall_clr) begin
      m0_stall_cnt <= '0;
      m1_stall_cnt <= '0;
    end else begin
      if (req0 && !gnt0 && !(&m0_stall_cnt)) begin
        m0_stall_cnt <= m0_stall_cnt + STALL_ONE;
      end
      if (req1 && !gnt1 && !(&m1_stall_cnt)) begin
        m1_stall_cnt <= m1_stall_cnt + STALL_ONE;
      end
    end
  end

endmodule

// File: tb/tb_onchip_mem_arbiter.sv
// Bench for onchip_mem_arbiter: behavioural RAM slave, a cycle monitor with a
// read-return scoreboard, a vector table and hand-written corner sequences.
module tb_onchip_mem_arbiter;

  localparam int ADDR_W  = 13;
  localparam int DATA_W  = 32;
  localparam int BE_W    = 4;
  localparam int STALL_W = 4;
  localparam int DEPTH   = 1 << ADDR_W;

  logic               clk;
  logic               reset_n;
  logic [ADDR_W-1:0]  m0_address, m1_address;
  logic [BE_W-1:0]    m0_byteenable, m1_byteenable;
  logic               m0_read, m0_write, m1_read, m1_write;
  logic [DATA_W-1:0]  m0_writedata, m1_writedata;
  logic               m0_waitrequest, m1_waitrequest;
  logic [DATA_W-1:0]  m0_readdata, m1_readdata;
  logic               m0_readdatavalid, m1_readdatavalid;
  logic [ADDR_W-1:0]  mem_address;
  logic [BE_W-1:0]    mem_byteenable;
  logic               mem_chipselect, mem_write, mem_clken;
  logic [DATA_W-1:0]  mem_writedata, mem_readdata;
  logic               stall_clr;
  logic [STALL_W-1:0] m0_stall_cnt, m1_stall_cnt;

  int errors = 0;
  int checks = 0;
  bit mon_en = 0;
  int rdv0_cnt = 0;
  int rdv1_cnt = 0;

  onchip_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BE_W(BE_W), .STALL_W(STALL_W)) dut (
    .clk(clk), .reset_n(reset_n),
    .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
    .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_waitrequest(m0_waitrequest),
    .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
    .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
    .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_waitrequest(m1_waitrequest),
    .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
    .mem_address(mem_address), .mem_byteenable(mem_byteenable),
    .mem_chipselect(mem_chipselect), .mem_write(mem_write),
    .mem_writedata(mem_writedata), .mem_clken(mem_clken), .mem_readdata(mem_readdata),
    .stall_clr(stall_clr), .m0_stall_cnt(m0_stall_cnt), .m1_stall_cnt(m1_stall_cnt)
  );

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- RAM slave (latency 1) and reference contents ----------------
  logic [DATA_W-1:0] ram     [DEPTH];
  logic [DATA_W-1:0] ref_mem [DEPTH];

  always @(posedge clk) begin
    if (mem_clken && mem_chipselect) begin
      if (mem_write) begin
        for (int b = 0; b < BE_W; b++)
          if (mem_byteenable[b]) ram[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
      end else begin
        mem_readdata <= ram[mem_address];
      end
    end
  end

  task automatic ref_write(input logic [ADDR_W-1:0] a, input logic [BE_W-1:0] be,
                           input logic [DATA_W-1:0] d);
    for (int b = 0; b < BE_W; b++)
      if (be[b]) ref_mem[a][8*b +: 8] = d[8*b +: 8];
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  logic [DATA_W-1:0] exp0_q[$];
  logic [DATA_W-1:0] exp1_q[$];
  logic              mdl_lg = 1'b1;
  logic              pend0 = 1'b0, pend1 = 1'b0;
  logic [STALL_W-1:0] mst0 = '0, mst1 = '0;

  always @(negedge clk) begin : monitor
    logic r0, r1, g0, g1;
    if (mon_en) begin
      r0 = m0_read | m0_write;
      r1 = m1_read | m1_write;
      g0 = reset_n & r0 & (!r1 | mdl_lg);
      g1 = reset_n & r1 & (!r0 | !mdl_lg);
      chk("wait0", m0_waitrequest, !g0);
      chk("wait1", m1_waitrequest, !g1);
      chk("chipselect", mem_chipselect, g0 | g1);
      chk("mem_write", mem_write, (g0 & m0_write) | (g1 & m1_write));
      if (g0 | g1) chk("mem_address", mem_address, g1 ? m1_address : m0_address);
      if (g0 & m0_write) chk("mem_wdata0", {mem_byteenable, mem_writedata[27:0]},
                             {m0_byteenable, m0_writedata[27:0]});
      if (g1 & m1_write) chk("mem_wdata1", {mem_byteenable, mem_writedata[27:0]},
                             {m1_byteenable, m1_writedata[27:0]});

      chk("rdvalid0", m0_readdatavalid, reset_n & pend0);
      chk("rdvalid1", m1_readdatavalid, reset_n & pend1);
      if (reset_n && pend0 && exp0_q.size() > 0) begin
        chk("rdata0", m0_readdata, exp0_q.pop_front());
        rdv0_cnt++;
      end else chk("rdata0_idle", m0_readdata, 32'h0);
      if (reset_n && pend1 && exp1_q.size() > 0) begin
        chk("rdata1", m1_readdata, exp1_q.pop_front());
        rdv1_cnt++;
      end else chk("rdata1_idle", m1_readdata, 32'h0);

      chk("stall_cnt0", m0_stall_cnt, mst0);
      chk("stall_cnt1", m1_stall_cnt, mst1);

      if (!reset_n) begin
        mdl_lg = 1'b1; pend0 = 1'b0; pend1 = 1'b0; mst0 = '0; mst1 = '0;
        exp0_q.delete(); exp1_q.delete();
      end else begin
        if (g0) begin
          mdl_lg = 1'b0;
          if (m0_write) ref_write(m0_address, m0_byteenable, m0_writedata);
          else exp0_q.push_back(ref_mem[m0_address]);
        end
        if (g1) begin
          mdl_lg = 1'b1;
          if (m1_write) ref_write(m1_address, m1_byteenable, m1_writedata);
          else exp1_q.push_back(ref_mem[m1_address]);
        end
        pend0 = g0 & m0_read & !m0_write;
        pend1 = g1 & m1_read & !m1_write;
        if (stall_clr) begin
          mst0 = '0; mst1 = '0;
        end else begin
          if (r0 && !g0 && mst0 != '1) mst0 = mst0 + 1'b1;
          if (r1 && !g1 && mst1 != '1) mst1 = mst1 + 1'b1;
        end
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic set_m0(input logic r, input logic w, input logic [ADDR_W-1:0] a,
                        input logic [BE_W-1:0] be, input logic [DATA_W-1:0] d);
    m0_read = r; m0_write = w; m0_address = a; m0_byteenable = be; m0_writedata = d;
  endtask

  task automatic set_m1(input logic r, input logic w, input logic [ADDR_W-1:0] a,
                        input logic [BE_W-1:0] be, input logic [DATA_W-1:0] d);
    m1_read = r; m1_write = w; m1_address = a; m1_byteenable = be; m1_writedata = d;
  endtask

  task automatic idle();
    set_m0(1'b0, 1'b0, '0, '0, '0);
    set_m1(1'b0, 1'b0, '0, '0, '0);
    stall_clr = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic              m0r, m0w;
    logic [ADDR_W-1:0] a0;
    logic [BE_W-1:0]   be0;
    logic [DATA_W-1:0] wd0;
    logic              m1r, m1w;
    logic [ADDR_W-1:0] a1;
    logic [BE_W-1:0]   be1;
    logic [DATA_W-1:0] wd1;
    logic              ew0, ew1;
    logic              erv0, erv1;
    logic [DATA_W-1:0] erd;
  } vec_t;

  localparam int NVEC = 13;
  vec_t vecs[NVEC];

  initial begin
    reset_n = 1'b0;
    idle();
    set_m0(1'b1, 1'b0, 13'h0001, 4'hF, '0);
    for (int i = 0; i < DEPTH; i++) begin
      ram[i]     = 32'hA500_0000 ^ i;
      ref_mem[i] = 32'hA500_0000 ^ i;
    end

    //          m0r  m0w  a0        be0   wd0            m1r  m1w  a1        be1   wd1            ew0  ew1  erv0 erv1 erd
    vecs[0]  = '{1'b0,1'b1,13'h0010,4'hF,32'hDEADBEEF, 1'b0,1'b0,13'h0000,4'h0,32'h0,         1'b0,1'b1,1'b0,1'b0,32'h0};
    vecs[1]  = '{1'b1,1'b0,13'h0010,4'hF,32'h0,        1'b0,1'b0,13'h0000,4'h0,32'h0,         1'b0,1'b1,1'b0,1'b0,32'h0};
    vecs[2]  = '{1'b0,1'b0,13'h0000,4'h0,32'h0,        1'b0,1'b0,13'h0000,4'h0,32'h0,         1'b1,1'b1,1'b1,1'b0,32'hDEADBEEF};
    vecs[3]  = '{1'b0,1'b0,13'h0000,4'h0,32'h0,        1'b0,1'b1,13'h1FFF,4'hF,32'hFFFFFFFF,  1'b1,1'b0,1'b0,1'b0,32'h0};
    vecs[4]  = '{1'b0,1'b0,13'h0000,4'h0,32'h0,        1'b0,1'b1,13'h1FFF,4'h3,32'h12345678,  1'b1,1'b0,1'b0,1'b0,32'h0};
    vecs[5]  = '{1'b1,1'b0,13'h1FFF,4'hF,32'h0,        1'b0,1'b0,13'h0000,4'h0,32'h0,         1'b0,1'b1,1'b0,1'b0,32'h0};
    vecs[6]  = '{1'b1,1'b0,13'h0001,4'hF,32'h0,        1'b1,1'b0,13'h0002,4'hF,32'h0,         1'b1,1'b0,1'b1,1'b0,32'hFFFF5678};
    vecs[7]  = '{1'b1,1'b0,13'h0001,4'hF,32'h0,        1'b1,1'b0,13'h0002,4'hF,32'h0,         1'b0,1'b1,1'b0,1'b1,32'hA5000002};
    vecs[8]  = '{1'b1,1'b1,13'h0020,4'hF,32'hCAFEF00D, 1'b0,1'b0,13'h0000,4'h0,32'h0,         1'b0,1'b1,1'b1,1'b0,32'hA5000001};
    vecs[9]  = '{1'b0,1'b0,13'h0000,4'h0,32'h0,        1'b1,1'b0,13'h0020,4'hF,32'h0,         1'b1,1'b0,1'b0,1'b0,32'h0};
    vecs[10] = '{1'b0,1'b1,13'h0030,4'hF,32'h00000001, 1'b0,1'b1,13'h0031,4'hF,32'h00000002,  1'b0,1'b1,1'b0,1'b1,32'hCAFEF00D};
    vecs[11] = '{1'b0,1'b1,13'h0030,4'hF,32'h00000001, 1'b0,1'b1,13'h0031,4'hF,32'h00000002,  1'b1,1'b0,1'b0,1'b0,32'h0};
    vecs[12] = '{1'b0,1'b0,13'h0000,4'h0,32'h0,        1'b0,1'b0,13'h0000,4'h0,32'h0,         1'b1,1'b1,1'b0,1'b0,32'h0};

    // ---- reset with m0 requesting ----
    next_cycle();
    mon_en = 1'b1;
    @(negedge clk);
    chk("rst_wait0", m0_waitrequest, 1'b1);
    chk("rst_cs", mem_chipselect, 1'b0);
    chk("rst_rdv0", m0_readdatavalid, 1'b0);
    next_cycle();
    next_cycle();
    reset_n = 1'b1;
    @(negedge clk);
    chk("release_grant_m0", m0_waitrequest, 1'b0);
    next_cycle();
    idle();

    // ---- table-driven vectors ----
    for (int i = 0; i < NVEC; i++) begin
      next_cycle();
      set_m0(vecs[i].m0r, vecs[i].m0w, vecs[i].a0, vecs[i].be0, vecs[i].wd0);
      set_m1(vecs[i].m1r, vecs[i].m1w, vecs[i].a1, vecs[i].be1, vecs[i].wd1);
      @(negedge clk);
      chk($sformatf("vec%0d_wait0", i), m0_waitrequest, vecs[i].ew0);
      chk($sformatf("vec%0d_wait1", i), m1_waitrequest, vecs[i].ew1);
      chk($sformatf("vec%0d_rdv0", i), m0_readdatavalid, vecs[i].erv0);
      chk($sformatf("vec%0d_rdv1", i), m1_readdatavalid, vecs[i].erv1);
      if (vecs[i].erv0) chk($sformatf("vec%0d_rdata0", i), m0_readdata, vecs[i].erd);
      if (vecs[i].erv1) chk($sformatf("vec%0d_rdata1", i), m1_readdata, vecs[i].erd);
    end

    // ---- continuous contention, 8 cycles ----
    next_cycle();
    idle();
    stall_clr = 1'b1;
    rdv0_cnt = 0;
    rdv1_cnt = 0;
    next_cycle();
    stall_clr = 1'b0;
    set_m0(1'b1, 1'b0, 13'h0001, 4'hF, '0);
    set_m1(1'b1, 1'b0, 13'h0002, 4'hF, '0);
    repeat (8) next_cycle();
    idle();
    next_cycle();
    @(negedge clk);
    chk("contend_stall0", m0_stall_cnt, 4);
    chk("contend_stall1", m1_stall_cnt, 4);
    chk("contend_rdv0_count", rdv0_cnt, 4);
    chk("contend_rdv1_count", rdv1_cnt, 4);

    // ---- saturation, then clear against a stall ----
    next_cycle();
    set_m0(1'b1, 1'b0, 13'h0003, 4'hF, '0);
    set_m1(1'b1, 1'b0, 13'h0004, 4'hF, '0);
    repeat (40) next_cycle();
    stall_clr = 1'b1;
    @(negedge clk);
    chk("sat_stall0", m0_stall_cnt, 4'hF);
    chk("sat_stall1", m1_stall_cnt, 4'hF);
    next_cycle();
    idle();
    @(negedge clk);
    chk("clr_stall0", m0_stall_cnt, 0);
    chk("clr_stall1", m1_stall_cnt, 0);

    // ---- reset the cycle after an m1 read is granted ----
    next_cycle();
    next_cycle();
    rdv1_cnt = 0;
    set_m1(1'b1, 1'b0, 13'h0005, 4'hF, '0);
    @(negedge clk);
    chk("midrd_grant1", m1_waitrequest, 1'b0);
    next_cycle();
    idle();
    reset_n = 1'b0;
    @(negedge clk);
    chk("midrd_rdv1_in_reset", m1_readdatavalid, 1'b0);
    next_cycle();
    next_cycle();
    reset_n = 1'b1;
    repeat (3) next_cycle();
    @(negedge clk);
    chk("midrd_no_rdv1", rdv1_cnt, 0);

    // ---- random traffic on a small address window ----
    for (int i = 0; i < 300; i++) begin
      next_cycle();
      set_m0($urandom_range(0, 1), $urandom_range(0, 1), 13'($urandom_range(0, 7)),
             4'($urandom_range(0, 15)), $urandom);
      set_m1($urandom_range(0, 1), $urandom_range(0, 1), 13'($urandom_range(0, 7)),
             4'($urandom_range(0, 15)), $urandom);
      stall_clr = ($urandom_range(0, 31) == 0);
    end
    next_cycle();
    idle();
    repeat (2) next_cycle();
    @(negedge clk);
    chk("drain_q0", exp0_q.size(), 0);
    chk("drain_q1", exp1_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
